// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: adds a WIDTH-bit operand pair STEP bits per clock,
// carrying between chunks through a flip-flop, under a start/busy/done handshake.
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             dbg_state
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = (N + 1 <= 2) ? 1 : $clog2(N + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_partial;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_last;
  logic [STEP:0]    w_chunk;
  logic [STEP-1:0]  w_s;
  logic             w_cy;
  logic             w_msb_cin;
  logic [WIDTH-1:0] w_partial_next;

  // Handshake: start is taken only in IDLE; busy covers the whole run and done
  // pulses for the single cycle after the last chunk, never together with busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state == S_RUN);
    dbg_state = (r_state == S_RUN);
  end

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_state == S_RUN) && (r_cnt == LAST_CNT);

  assign w_chunk = {1'b0, r_a[STEP-1:0]} + {1'b0, r_b[STEP-1:0]} + {{STEP{1'b0}}, r_carry};
  assign w_s     = w_chunk[STEP-1:0];
  assign w_cy    = w_chunk[STEP];

  // The carry into the chunk's top bit is recovered from that bit's sum and operands.
  assign w_msb_cin = w_s[STEP-1] ^ r_a[STEP-1] ^ r_b[STEP-1];

  assign w_partial_next = WIDTH'({w_s, r_partial} >> STEP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_partial <= '0;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
      done      <= 1'b0;
      sum       <= '0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (w_accept) begin
        // Subtraction runs as a + ~b + !c_in, so the borrow-in flips the carry seed.
        r_a       <= a;
        r_b       <= sub ? ~b : b;
        r_carry   <= c_in ^ sub;
        r_cnt     <= '0;
        r_partial <= '0;
      end else if (r_state == S_RUN) begin
        r_a       <= r_a >> STEP;
        r_b       <= r_b >> STEP;
        r_partial <= w_partial_next;
        r_carry   <= w_cy;
        r_cnt     <= r_cnt + 1'b1;
        if (w_last) begin
          sum   <= w_partial_next;
          c_out <= w_cy;
          ovf   <= w_msb_cin ^ w_cy;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: four parameterisations, directed cases, reset and
// handshake scenarios, and random operands scored against an arithmetic model.
module tb_seq_chunk_adder;

  localparam int NI = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NI-1:0]   start_v, cin_v, sub_v;
  logic [NI-1:0]   busy_v, done_v, cout_v, ovf_v, dbg_v;
  logic [15:0]     a_v [NI];
  logic [15:0]     b_v [NI];
  logic [15:0]     sum_v [NI];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [17:0] exp_q[$];
  int          exp_cyc_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- DUT instances ----------------
  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int W = (g == 3) ? 8 : 16;
    localparam int S = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 16 : 8;
    logic [W-1:0] w_sum;
    seq_chunk_adder #(.WIDTH(W), .STEP(S)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start_v[g]),
      .a        (a_v[g][W-1:0]),
      .b        (b_v[g][W-1:0]),
      .c_in     (cin_v[g]),
      .sub      (sub_v[g]),
      .busy     (busy_v[g]),
      .done     (done_v[g]),
      .sum      (w_sum),
      .c_out    (cout_v[g]),
      .ovf      (ovf_v[g]),
      .dbg_state(dbg_v[g])
    );
    assign sum_v[g] = 16'(w_sum);
  end

  function automatic int w_of(int k);
    return (k == 3) ? 8 : 16;
  endfunction

  function automatic int n_of(int k);
    case (k)
      0:       return 4;
      1:       return 16;
      default: return 1;
    endcase
  endfunction

  // Reference: plain integer arithmetic on the operands, returns {ovf, c_out, sum}.
  function automatic logic [17:0] model(int w, logic [15:0] a, logic [15:0] b,
                                        logic cin, logic sub);
    longint mask = (longint'(1) << w) - 1;
    longint half = longint'(1) << (w - 1);
    longint ua   = longint'(a) & mask;
    longint ub   = longint'(b) & mask;
    longint ci   = longint'(cin);
    longint sa, sb, res, full;
    logic   co, ov;
    sa = (ua >= half) ? ua - 2 * half : ua;
    sb = (ub >= half) ? ub - 2 * half : ub;
    if (!sub) begin
      full = ua + ub + ci;
      co   = (full > mask);
      res  = sa + sb + ci;
    end else begin
      full = ua - ub - ci;
      co   = (full >= 0);
      res  = sa - sb - ci;
    end
    ov = (res < -half) || (res > half - 1);
    return {ov, co, 16'(full & mask)};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [17:0] e;
    int          ec;
    for (int k = 0; k < NI; k++) begin
      if (done_v[k] === 1'b1) begin
        if (exp_q.size() == 0) begin
          check($sformatf("unexpected_done[%0d]", k), 32'd1, 32'd0);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check($sformatf("result[%0d]", k), {14'd0, ovf_v[k], cout_v[k], sum_v[k]}, {14'd0, e});
          check($sformatf("latency[%0d]", k), cyc, ec);
          check($sformatf("busy_at_done[%0d]", k), {31'd0, busy_v[k]}, 32'd0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(int k, logic [15:0] a, logic [15:0] b, logic cin, logic sub);
    a_v[k]     = a;
    b_v[k]     = b;
    cin_v[k]   = cin;
    sub_v[k]   = sub;
    start_v[k] = 1'b1;
    exp_q.push_back(model(w_of(k), a, b, cin, sub));
    exp_cyc_q.push_back(cyc + 1 + n_of(k));
    @(posedge clk); #1;
    start_v[k] = 1'b0;
    a_v[k]     = 16'($urandom);
    b_v[k]     = 16'($urandom);
    cin_v[k]   = 1'($urandom);
    sub_v[k]   = 1'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  task automatic run_op(int k, logic [15:0] a, logic [15:0] b, logic cin, logic sub);
    issue(k, a, b, cin, sub);
    drain();
  endtask

  task automatic check_cleared(int k, string tag);
    check($sformatf("%s_busy[%0d]", tag, k),  {31'd0, busy_v[k]}, 32'd0);
    check($sformatf("%s_done[%0d]", tag, k),  {31'd0, done_v[k]}, 32'd0);
    check($sformatf("%s_sum[%0d]", tag, k),   {16'd0, sum_v[k]},  32'd0);
    check($sformatf("%s_cout[%0d]", tag, k),  {31'd0, cout_v[k]}, 32'd0);
    check($sformatf("%s_ovf[%0d]", tag, k),   {31'd0, ovf_v[k]},  32'd0);
    check($sformatf("%s_state[%0d]", tag, k), {31'd0, dbg_v[k]},  32'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] d_a   [6] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0005, 16'h0005};
  logic [15:0] d_b   [6] = '{16'h4321, 16'h0001, 16'h0001, 16'h0001, 16'h0007, 16'h0003};
  logic        d_cin [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic        d_sub [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [17:0] d_exp [6] = '{{2'b00, 16'h5555}, {2'b01, 16'h0000}, {2'b10, 16'h8000},
                             {2'b11, 16'h7FFF}, {2'b00, 16'hFFFE}, {2'b01, 16'h0001}};

  initial begin
    int c0;
    rst     = 1'b1;
    start_v = '0;
    cin_v   = '0;
    sub_v   = '0;
    for (int k = 0; k < NI; k++) begin
      a_v[k] = '0;
      b_v[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) check_cleared(k, "por");
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases on WIDTH=16, STEP=4.
    for (int i = 0; i < 6; i++) begin
      run_op(0, d_a[i], d_b[i], d_cin[i], d_sub[i]);
      check($sformatf("directed_%0d", i), {14'd0, ovf_v[0], cout_v[0], sum_v[0]}, {14'd0, d_exp[i]});
    end

    // Reset in the middle of a run discards the operation.
    issue(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    exp_cyc_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check_cleared(0, "midrun_rst");
    rst = 1'b0;
    repeat (n_of(0) + 4) @(posedge clk);
    #1;

    // start pulsed during a run is ignored.
    issue(0, 16'h1111, 16'h2222, 1'b0, 1'b0);
    @(posedge clk); #1;
    start_v[0] = 1'b1;
    a_v[0]     = 16'hABCD;
    b_v[0]     = 16'h1234;
    sub_v[0]   = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    drain();
    check("ignored_start", {14'd0, ovf_v[0], cout_v[0], sum_v[0]}, {14'd0, 2'b00, 16'h3333});

    // start held high: second op accepted on the done cycle.
    c0         = cyc;
    a_v[0]     = 16'h1000;
    b_v[0]     = 16'h0234;
    cin_v[0]   = 1'b0;
    sub_v[0]   = 1'b0;
    start_v[0] = 1'b1;
    exp_q.push_back(model(16, 16'h1000, 16'h0234, 1'b0, 1'b0));
    exp_cyc_q.push_back(c0 + 1 + n_of(0));
    @(posedge clk); #1;
    a_v[0]   = 16'h0F00;
    b_v[0]   = 16'h0100;
    cin_v[0] = 1'b1;
    sub_v[0] = 1'b1;
    exp_q.push_back(model(16, 16'h0F00, 16'h0100, 1'b1, 1'b1));
    exp_cyc_q.push_back(c0 + 2 + 2 * n_of(0));
    repeat (n_of(0) + 1) @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    drain();
    check("held_start_result", {16'd0, sum_v[0]}, 32'h0000_0DFF);

    // Random sweep over all parameterisations.
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 1000; i++) begin
        run_op(k, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
      end
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
